kersram_r: RTL

//  Kernel SRAM read engine, the read side of the 8-bank kernel store. On start it sweeps

---
 rtl/kersram_r.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/kersram_r.sv
// kersram_r: kernel SRAM read engine. Sweeps all 8 banks in lockstep and streams 512-bit beats.
// Define KER_RD_RPT_EN to add ker_read_repeat_din and back-to-back multi-pass sweeps.
module kersram_r #(
  parameter int ADDR_CNT_BITS = 10,
  parameter int KER_RD_LENGTH = 288,
  parameter int RPT_BITS      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_ker_read,
  output logic                     ker_read_busy,
  output logic                     ker_read_done,
  output logic                     cen_kersr_0,
  output logic                     cen_kersr_1,
  output logic                     cen_kersr_2,
  output logic                     cen_kersr_3,
  output logic                     cen_kersr_4,
  output logic                     cen_kersr_5,
  output logic                     cen_kersr_6,
  output logic                     cen_kersr_7,
  output logic                     wen_kersr_0,
  output logic                     wen_kersr_1,
  output logic                     wen_kersr_2,
  output logic                     wen_kersr_3,
  output logic                     wen_kersr_4,
  output logic                     wen_kersr_5,
  output logic                     wen_kersr_6,
  output logic                     wen_kersr_7,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_0,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_1,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_2,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_3,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_4,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_5,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_6,
  output logic [ADDR_CNT_BITS-1:0] addr_kersr_7,
  input  logic [63:0]              dout_kersr_0,
  input  logic [63:0]              dout_kersr_1,
  input  logic [63:0]              dout_kersr_2,
  input  logic [63:0]              dout_kersr_3,
  input  logic [63:0]              dout_kersr_4,
  input  logic [63:0]              dout_kersr_5,
  input  logic [63:0]              dout_kersr_6,
  input  logic [63:0]              dout_kersr_7,
  output logic [511:0]             ker_read_data_dout,
  output logic                     ker_read_valid_dout,
  input  logic                     ker_read_ready_din
`ifdef KER_RD_RPT_EN
  ,
  input  logic [RPT_BITS-1:0]      ker_read_repeat_din
`endif
);

  localparam logic [ADDR_CNT_BITS-1:0] LAST_ADDR = ADDR_CNT_BITS'(KER_RD_LENGTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                   r_state;
  logic [ADDR_CNT_BITS-1:0] r_addr;
  logic                     r_inflight;
  logic [1:0]               r_count;
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [511:0]             r_buf [2];

  logic [511:0]             w_dout;
  logic                     w_issue;
  logic                     w_pop;
  logic                     w_addr_wrap;
  logic                     w_last_pass;
  logic                     w_last_issue;
  logic [1:0]               w_count_next;

  if (KER_RD_LENGTH < 1 || KER_RD_LENGTH > (1 << ADDR_CNT_BITS) || RPT_BITS < 1) begin : g_bad_params
  end

  assign w_dout = {dout_kersr_7, dout_kersr_6, dout_kersr_5, dout_kersr_4,
                   dout_kersr_3, dout_kersr_2, dout_kersr_1, dout_kersr_0};

  // Credit check uses registered occupancy only, so ready never reaches the SRAM enables.
  assign w_issue      = (r_state == S_READ) && ((r_count + {1'b0, r_inflight}) < 2'd2);
  assign w_pop        = (r_count != 2'd0) && ker_read_ready_din;
  assign w_addr_wrap  = (r_addr == LAST_ADDR);
  assign w_count_next = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

`ifdef KER_RD_RPT_EN
  logic [RPT_BITS-1:0] r_pass;
  logic [RPT_BITS-1:0] r_pass_last;
  assign w_last_pass = (r_pass == r_pass_last);
`else
  assign w_last_pass = 1'b1;
`endif

  assign w_last_issue = w_issue && w_addr_wrap && w_last_pass;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_inflight <= 1'b0;
`ifdef KER_RD_RPT_EN
      r_pass      <= '0;
      r_pass_last <= '0;
`endif
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr <= w_addr_wrap ? '0 : r_addr + 1'b1;
`ifdef KER_RD_RPT_EN
        if (w_addr_wrap) r_pass <= r_pass + 1'b1;
`endif
      end
      case (r_state)
        S_IDLE: begin
          if (start_ker_read) begin
            r_state <= S_READ;
`ifdef KER_RD_RPT_EN
            r_pass      <= '0;
            r_pass_last <= (ker_read_repeat_din == '0) ? '0 : ker_read_repeat_din - RPT_BITS'(1);
`endif
          end
        end
        S_READ:  if (w_last_issue) r_state <= S_DRAIN;
        // Nothing issues in DRAIN, so an empty next count means the last beat has left.
        S_DRAIN: if (w_count_next == 2'd0) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
    end else begin
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= w_dout;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_next;
    end
  end

  assign ker_read_busy       = (r_state == S_READ) || (r_state == S_DRAIN);
  assign ker_read_done       = (r_state == S_DONE);
  assign ker_read_valid_dout = (r_count != 2'd0);
  assign ker_read_data_dout  = r_buf[r_rd_ptr];

  assign cen_kersr_0 = ~w_issue;
  assign cen_kersr_1 = ~w_issue;
  assign cen_kersr_2 = ~w_issue;
  assign cen_kersr_3 = ~w_issue;
  assign cen_kersr_4 = ~w_issue;
  assign cen_kersr_5 = ~w_issue;
  assign cen_kersr_6 = ~w_issue;
  assign cen_kersr_7 = ~w_issue;

  assign wen_kersr_0 = 1'b1;
  assign wen_kersr_1 = 1'b1;
  assign wen_kersr_2 = 1'b1;
  assign wen_kersr_3 = 1'b1;
  assign wen_kersr_4 = 1'b1;
  assign wen_kersr_5 = 1'b1;
  assign wen_kersr_6 = 1'b1;
  assign wen_kersr_7 = 1'b1;

  assign addr_kersr_0 = r_addr;
  assign addr_kersr_1 = r_addr;
  assign addr_kersr_2 = r_addr;
  assign addr_kersr_3 = r_addr;
  assign addr_kersr_4 = r_addr;
  assign addr_kersr_5 = r_addr;
  assign addr_kersr_6 = r_addr;
  assign addr_kersr_7 = r_addr;

endmodule
